// File: rtl/cordic_vec_if.sv
// Stream interface for cordic_vec_pipe: the sample input side with tag, and the
// result output side with back-pressure.
interface cordic_vec_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] xin;
  logic signed [WIDTH-1:0] yin;
  logic signed [WIDTH-1:0] x2in;
  logic signed [WIDTH-1:0] y2in;
  logic [TAG_W-1:0]        tag_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] length;
  logic signed [WIDTH-1:0] x2out;
  logic [TAG_W-1:0]        tag_out;

  modport master (
    output in_valid, xin, yin, x2in, y2in, tag_in, out_ready,
    input  in_ready, out_valid, length, x2out, tag_out
  );

  modport slave (
    input  in_valid, xin, yin, x2in, y2in, tag_in, out_ready,
    output in_ready, out_valid, length, x2out, tag_out
  );
endinterface

// File: rtl/cordic_vec_pipe.sv
// Pipelined vectoring CORDIC: |(x,y)| plus the companion x rotated by the same decisions.
// Define CORDIC_GAIN_COMP_EN to apply the 0.625 gain correction in the output slice.
module cordic_vec_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input logic        clk,
  input logic        reset,
  cordic_vec_if.slave bus
);
  localparam int DW = WIDTH + 2;
  typedef logic signed [DW-1:0] dw_t;

  dw_t              x_q  [STAGES];
  dw_t              y_q  [STAGES];
  dw_t              x2_q [STAGES];
  dw_t              y2_q [STAGES];
  logic [TAG_W-1:0] tag_q[STAGES];
  logic [STAGES-1:0] vld_q;

  dw_t              x_nx  [STAGES];
  dw_t              y_nx  [STAGES];
  dw_t              x2_nx [STAGES];
  dw_t              y2_nx [STAGES];
  logic [TAG_W-1:0] tag_up[STAGES];
  logic [STAGES-1:0] up_vld;
  logic [STAGES:0]   rdy;

  logic                    out_vld_q;
  logic signed [WIDTH-1:0] len_q;
  logic signed [WIDTH-1:0] x2o_q;
  logic [TAG_W-1:0]        tago_q;

  function automatic logic signed [WIDTH-1:0] sat(input dw_t v);
    dw_t hi, lo;
    hi = dw_t'((2 ** (WIDTH - 1)) - 1);
    lo = -dw_t'(2 ** (WIDTH - 1));
    if (v > hi) return hi[WIDTH-1:0];
    if (v < lo) return lo[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  function automatic dw_t comp(input dw_t v);
`ifdef CORDIC_GAIN_COMP_EN
    return (v >>> 1) + (v >>> 3);
`else
    return v;
`endif
  endfunction

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_iter
      dw_t xa, ya, x2a, y2a;
      if (i == 0) begin : g_entry
        // Mirror into the right half-plane; y keeps its sign.
        logic mirror;
        assign mirror = bus.xin[WIDTH-1];
        assign xa  = mirror ? -dw_t'(bus.xin)  : dw_t'(bus.xin);
        assign ya  = dw_t'(bus.yin);
        assign x2a = mirror ? -dw_t'(bus.x2in) : dw_t'(bus.x2in);
        assign y2a = dw_t'(bus.y2in);
      end else begin : g_chain
        assign xa  = x_q[i-1];
        assign ya  = y_q[i-1];
        assign x2a = x2_q[i-1];
        assign y2a = y2_q[i-1];
      end
      // Companion follows the primary's decision, never its own sign.
      assign x_nx[i]  = ya[DW-1] ? xa  - (ya  >>> i) : xa  + (ya  >>> i);
      assign y_nx[i]  = ya[DW-1] ? ya  + (xa  >>> i) : ya  - (xa  >>> i);
      assign x2_nx[i] = ya[DW-1] ? x2a - (y2a >>> i) : x2a + (y2a >>> i);
      assign y2_nx[i] = ya[DW-1] ? y2a + (x2a >>> i) : y2a - (x2a >>> i);
    end
  endgenerate

  always_comb begin
    up_vld    = '0;
    up_vld[0] = bus.in_valid;
    tag_up[0] = bus.tag_in;
    for (int k = 1; k < STAGES; k++) begin
      up_vld[k] = vld_q[k-1];
      tag_up[k] = tag_q[k-1];
    end
  end

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = !out_vld_q || bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !vld_q[k] || rdy[k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= '0;
      out_vld_q <= 1'b0;
      len_q     <= '0;
      x2o_q     <= '0;
      tago_q    <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= up_vld[k];
          if (up_vld[k]) begin
            x_q[k]   <= x_nx[k];
            y_q[k]   <= y_nx[k];
            x2_q[k]  <= x2_nx[k];
            y2_q[k]  <= y2_nx[k];
            tag_q[k] <= tag_up[k];
          end
        end
      end
      if (rdy[STAGES]) begin
        out_vld_q <= vld_q[STAGES-1];
        if (vld_q[STAGES-1]) begin
          len_q  <= sat(comp(x_q[STAGES-1]));
          x2o_q  <= sat(comp(x2_q[STAGES-1]));
          tago_q <= tag_q[STAGES-1];
        end
      end
    end
  end

  // Held high through reset so the producer never sees a stall it cannot explain.
  assign bus.in_ready  = rdy[0] || reset;
  assign bus.out_valid = out_vld_q;
  assign bus.length    = len_q;
  assign bus.x2out     = x2o_q;
  assign bus.tag_out   = tago_q;
endmodule

// File: tb/tb_cordic_vec_pipe.sv
// Directed bench for cordic_vec_pipe (WIDTH=16, STAGES=3); expected values are
// hand-derived for both the compensated and raw output builds.
module tb_cordic_vec_pipe;
  localparam int WIDTH  = 16;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cordic_vec_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  cordic_vec_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int x, y, x2, y2;
    int len_c, x2_c, len_r, x2_r;
  } vec_t;
  typedef struct {
    int tag, len, x2;
  } exp_t;

  vec_t vecs[5];
  exp_t exp_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_acc, n_out, first_out, last_out, next_tag, cur_vi, cur_tag;
  logic last_acc;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_len(input int i);
`ifdef CORDIC_GAIN_COMP_EN
    return vecs[i].len_c;
`else
    return vecs[i].len_r;
`endif
  endfunction

  function automatic int exp_x2(input int i);
`ifdef CORDIC_GAIN_COMP_EN
    return vecs[i].x2_c;
`else
    return vecs[i].x2_r;
`endif
  endfunction

  task automatic offer(input int vi, input int tag);
    bus.xin      = 16'(vecs[vi].x);
    bus.yin      = 16'(vecs[vi].y);
    bus.x2in     = 16'(vecs[vi].x2);
    bus.y2in     = 16'(vecs[vi].y2);
    bus.tag_in   = 4'(tag);
    bus.in_valid = 1'b1;
    cur_vi       = vi;
    cur_tag      = tag;
  endtask

  // One clock: sample handshakes just before the edge, score drains, log accepts.
  task automatic step();
    logic acc, drn;
    exp_t e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    drn = bus.out_valid && bus.out_ready;
    if (drn) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", int'(bus.tag_out), -1);
      end else begin
        e = exp_q.pop_front();
        chk("out_tag", int'(bus.tag_out), e.tag);
        chk("out_length", int'(bus.length), e.len);
        chk("out_x2", int'(bus.x2out), e.x2);
      end
      n_out++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (acc) begin
      e.tag = cur_tag;
      e.len = exp_len(cur_vi);
      e.x2  = exp_x2(cur_vi);
      exp_q.push_back(e);
      n_acc++;
    end
    last_acc = acc;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic single_latency(input int vi, input int tag);
    int lat;
    offer(vi, tag);
    #1;
    chk("lat_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, STAGES + 1);
    chk("lat_tag", int'(bus.tag_out), tag);
    chk("lat_length", int'(bus.length), exp_len(vi));
    chk("lat_x2", int'(bus.x2out), exp_x2(vi));
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("lat_drained", int'(bus.out_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // x, y, x2, y2, length/x2out compensated, length/x2out raw
    vecs[0] = '{1000, 0, 2000, 0, 1015, 2031, 1625, 3250};
    vecs[1] = '{0, -1000, 0, 0, 1015, 0, 1625, 0};
    vecs[2] = '{-1000, 0, -2000, 0, 1015, 2031, 1625, 3250};
    vecs[3] = '{32767, 32767, -32768, -32768, 32767, -32768, 32767, -32768};
    vecs[4] = '{3, 4, 100, 50, 5, 97, 8, 157};

    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.xin = '0; bus.yin = '0; bus.x2in = '0; bus.y2in = '0; bus.tag_in = '0;
    first_out = -1; last_out = -1; n_acc = 0; n_out = 0; cur_vi = 0; cur_tag = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_length", int'(bus.length), 0);
    chk("rst_x2out", int'(bus.x2out), 0);
    chk("rst_tag_out", int'(bus.tag_out), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);

    bus.out_ready = 1'b1;
    single_latency(0, 9);

    // Back-to-back stream of all vectors
    n_acc = 0; n_out = 0; first_out = -1;
    for (int i = 0; i < 5; i++) begin
      offer(i, i + 1);
      step();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    chk("stream_accepted", n_acc, 5);
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_gapless", last_out - first_out, 4);

    // Back-pressure: fill with out_ready low, then release
    bus.out_ready = 1'b0;
    n_acc = 0; n_out = 0; first_out = -1; next_tag = 1;
    for (int k = 0; k < 6; k++) begin
      offer((next_tag - 1) % 5, next_tag);
      step();
      if (last_acc) next_tag++;
    end
    chk("bp_accepted", n_acc, STAGES + 1);
    #1;
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("bp_stall_valid", int'(bus.out_valid), 1);
    step();
    chk("bp_hold_tag", int'(bus.tag_out), 1);
    chk("bp_hold_length", int'(bus.length), exp_len(0));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && next_tag <= 6; k++) begin
      offer((next_tag - 1) % 5, next_tag);
      step();
      if (last_acc) next_tag++;
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_out_count", n_out, 6);
    chk("bp_gapless", last_out - first_out, 5);

    // Reset mid-stream discards in-flight samples
    n_acc = 0;
    for (int t = 11; t <= 13; t++) begin
      offer(t - 11, t);
      step();
    end
    chk("mid_accepted", n_acc, 3);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_out_valid", int'(bus.out_valid), 0);
    chk("mid_length", int'(bus.length), 0);
    chk("mid_x2out", int'(bus.x2out), 0);
    chk("mid_tag_out", int'(bus.tag_out), 0);
    chk("mid_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    n_out = 0;
    repeat (6) step();
    chk("no_stale", n_out, 0);
    single_latency(4, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
